// File: rtl/sme_pkg.sv
// sme_pkg: shared widths and FSM state encoding for the SME arbiter.
package sme_pkg;

  localparam int unsigned STR_AW = 5;
  localparam int unsigned PAT_AW = 3;
  localparam int unsigned REQ_N  = 2;
  localparam int unsigned DW     = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_STR = 3'd1,
    SEND_PAT = 3'd2,
    WAIT     = 3'd3,
    RESP     = 3'd4
  } sme_state_e;

endpackage

// File: rtl/sme_rr_arb.sv
// sme_rr_arb: two-way round-robin pick; a tie goes to the requester not granted last.
module sme_rr_arb
  import sme_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic             last_grant,
  output logic             grant_c
);

  // Single requester wins outright; on a tie alternate away from last_grant
  always_comb begin
    grant_c = 1'b0;
    if (req[0] && req[1]) begin
      grant_c = ~last_grant;
    end else if (req[1]) begin
      grant_c = 1'b1;
    end
  end

endmodule

// File: rtl/sme_arbiter.sv
// sme_arbiter: shares one string-matching engine between two requesters.
// Streams the string (unless the engine already holds the owner's string) and
// the pattern byte by byte, waits for the engine result, then pulses done.
// Build option: define SME_ARB_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYC cycles.
module sme_arbiter
  import sme_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_N-1:0]  req,
  input  logic [REQ_N-1:0]  keep_str,
  input  logic [STR_AW-1:0] str_len_0,
  input  logic [STR_AW-1:0] str_len_1,
  input  logic [PAT_AW-1:0] pat_len_0,
  input  logic [PAT_AW-1:0] pat_len_1,
  output logic              rd_sel,
  output logic [STR_AW-1:0] rd_addr,
  output logic              rd_is_pat,
  input  logic [DW-1:0]     rd_data,
  output logic [DW-1:0]     sme_chardata,
  output logic              sme_isstring,
  output logic              sme_ispattern,
  input  logic              sme_valid,
  input  logic              sme_match,
  input  logic [STR_AW-1:0] sme_match_index,
  output logic [REQ_N-1:0]  done,
  output logic              res_match,
  output logic [STR_AW-1:0] res_index,
  output logic              res_err,
  output logic              busy
);

  sme_state_e        state, state_nx;
  logic              rd_sel_nx, rd_is_pat_nx;
  logic [STR_AW-1:0] rd_addr_nx;
  logic [DW-1:0]     chardata_nx;
  logic              isstring_nx, ispattern_nx;
  logic [REQ_N-1:0]  done_nx;
  logic              res_match_nx;
  logic [STR_AW-1:0] res_index_nx;
  logic              busy_nx;
  logic              last_grant, last_grant_nx;
  logic              str_loaded, str_loaded_nx;
  logic              str_owner, str_owner_nx;
  logic [STR_AW-1:0] str_len_q, str_len_nx;
  logic [PAT_AW-1:0] pat_len_q, pat_len_nx;
  logic              pat_drain, pat_drain_nx;
  logic              grant_c;

  sme_rr_arb u_rr_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant_c    (grant_c)
  );

`ifdef SME_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt, wait_cnt_nx;
  logic            res_err_nx;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign res_err        = 1'b0;
`endif

  // Next-state and registered-output decode; strobes lag the read address by one cycle
  always_comb begin
    state_nx      = state;
    rd_sel_nx     = rd_sel;
    rd_addr_nx    = rd_addr;
    rd_is_pat_nx  = rd_is_pat;
    chardata_nx   = sme_chardata;
    isstring_nx   = 1'b0;
    ispattern_nx  = 1'b0;
    done_nx       = '0;
    res_match_nx  = res_match;
    res_index_nx  = res_index;
    busy_nx       = 1'b0;
    last_grant_nx = last_grant;
    str_loaded_nx = str_loaded;
    str_owner_nx  = str_owner;
    str_len_nx    = str_len_q;
    pat_len_nx    = pat_len_q;
    pat_drain_nx  = pat_drain;
`ifdef SME_ARB_TIMEOUT_EN
    wait_cnt_nx   = wait_cnt;
    res_err_nx    = res_err;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          rd_sel_nx     = grant_c;
          last_grant_nx = grant_c;
          rd_addr_nx    = '0;
          pat_drain_nx  = 1'b0;
          str_len_nx    = grant_c ? str_len_1 : str_len_0;
          pat_len_nx    = grant_c ? pat_len_1 : pat_len_0;
          if (keep_str[grant_c] && str_loaded && (str_owner == grant_c)) begin
            state_nx     = SEND_PAT;
            rd_is_pat_nx = 1'b1;
          end else begin
            state_nx     = SEND_STR;
            rd_is_pat_nx = 1'b0;
          end
        end
      end
      SEND_STR: begin
        chardata_nx = rd_data;
        isstring_nx = 1'b1;
        if (rd_addr == str_len_q) begin
          state_nx      = SEND_PAT;
          rd_addr_nx    = '0;
          rd_is_pat_nx  = 1'b1;
          str_loaded_nx = 1'b1;
          str_owner_nx  = rd_sel;
        end else begin
          rd_addr_nx = rd_addr + STR_AW'(1);
        end
      end
      SEND_PAT: begin
        // One drain cycle lets the last pattern strobe retire before WAIT
        if (pat_drain) begin
          state_nx     = WAIT;
          pat_drain_nx = 1'b0;
`ifdef SME_ARB_TIMEOUT_EN
          wait_cnt_nx  = '0;
`endif
        end else begin
          chardata_nx  = rd_data;
          ispattern_nx = 1'b1;
          if (rd_addr == STR_AW'(pat_len_q)) begin
            pat_drain_nx = 1'b1;
          end else begin
            rd_addr_nx = rd_addr + STR_AW'(1);
          end
        end
      end
      WAIT: begin
        if (sme_valid) begin
          state_nx          = RESP;
          res_match_nx      = sme_match;
          res_index_nx      = sme_match_index;
          done_nx[rd_sel]   = 1'b1;
`ifdef SME_ARB_TIMEOUT_EN
          res_err_nx        = 1'b0;
        end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state_nx          = RESP;
          res_match_nx      = 1'b0;
          res_index_nx      = '0;
          res_err_nx        = 1'b1;
          str_loaded_nx     = 1'b0;
          done_nx[rd_sel]   = 1'b1;
        end else begin
          wait_cnt_nx       = wait_cnt + TO_W'(1);
`endif
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rd_sel        <= 1'b0;
      rd_addr       <= '0;
      rd_is_pat     <= 1'b0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      done          <= '0;
      res_match     <= 1'b0;
      res_index     <= '0;
      busy          <= 1'b0;
      last_grant    <= 1'b1;
      str_loaded    <= 1'b0;
      str_owner     <= 1'b0;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      pat_drain     <= 1'b0;
    end else begin
      state         <= state_nx;
      rd_sel        <= rd_sel_nx;
      rd_addr       <= rd_addr_nx;
      rd_is_pat     <= rd_is_pat_nx;
      sme_chardata  <= chardata_nx;
      sme_isstring  <= isstring_nx;
      sme_ispattern <= ispattern_nx;
      done          <= done_nx;
      res_match     <= res_match_nx;
      res_index     <= res_index_nx;
      busy          <= busy_nx;
      last_grant    <= last_grant_nx;
      str_loaded    <= str_loaded_nx;
      str_owner     <= str_owner_nx;
      str_len_q     <= str_len_nx;
      pat_len_q     <= pat_len_nx;
      pat_drain     <= pat_drain_nx;
    end
  end

`ifdef SME_ARB_TIMEOUT_EN
  // Watchdog counter and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      res_err  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nx;
      res_err  <= res_err_nx;
    end
  end
`endif

endmodule

// File: tb/tb_sme_arbiter.sv
// tb_sme_arbiter: randomized jobs checked against a job-level reference model.
module tb_sme_arbiter;

  localparam int unsigned TO_CYC = 64;

  logic       clk;
  logic       reset;
  logic [1:0] req, keep_str;
  logic [4:0] str_len_0, str_len_1;
  logic [2:0] pat_len_0, pat_len_1;
  logic       rd_sel;
  logic [4:0] rd_addr;
  logic       rd_is_pat;
  logic [7:0] rd_data;
  logic [7:0] sme_chardata;
  logic       sme_isstring, sme_ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_match_index;
  logic [1:0] done;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err, busy;

  logic [7:0] str_mem [2][32];
  logic [7:0] pat_mem [2][8];

  int   n_chk, n_fail;
  logic lg_m, loaded_m, owner_m;
  logic fix_res, fx_match;
  logic [4:0] fx_index;

  sme_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .keep_str        (keep_str),
    .str_len_0       (str_len_0),
    .str_len_1       (str_len_1),
    .pat_len_0       (pat_len_0),
    .pat_len_1       (pat_len_1),
    .rd_sel          (rd_sel),
    .rd_addr         (rd_addr),
    .rd_is_pat       (rd_is_pat),
    .rd_data         (rd_data),
    .sme_chardata    (sme_chardata),
    .sme_isstring    (sme_isstring),
    .sme_ispattern   (sme_ispattern),
    .sme_valid       (sme_valid),
    .sme_match       (sme_match),
    .sme_match_index (sme_match_index),
    .done            (done),
    .res_match       (res_match),
    .res_index       (res_index),
    .res_err         (res_err),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester buffers answer combinationally
  always_comb begin
    if (rd_is_pat) rd_data = pat_mem[rd_sel][rd_addr[2:0]];
    else           rd_data = str_mem[rd_sel][rd_addr];
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({rd_sel, rd_addr, rd_is_pat, sme_chardata, sme_isstring, sme_ispattern,
                done, res_match, res_index, res_err, busy});
  endfunction

  task automatic rand_lens();
    str_len_0 = 5'($urandom);
    str_len_1 = 5'($urandom);
    pat_len_0 = 3'($urandom);
    pat_len_1 = 3'($urandom);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lg_m     = 1'b1;
    loaded_m = 1'b0;
  endtask

  task automatic abort_job();
    logic seen;
    reset = 1'b0;
    #1;
    chk_eq("reset_outputs_mid", outs(), 32'd0);
    req       = 2'b00;
    sme_valid = 1'b0;
    seen      = 1'b0;
    repeat (2) begin @(negedge clk); seen |= |done; end
    reset = 1'b1;
    repeat (2) begin @(negedge clk); seen |= |done; end
    chk_eq("reset_no_done", 32'(seen), 32'd0);
    lg_m     = 1'b1;
    loaded_m = 1'b0;
  endtask

  // mode: 0 normal, 1 drop req after grant, 2 reset during pattern, 3 engine silent
  task automatic serve(input logic [1:0] rq, input logic [1:0] ks, input int mode);
    logic [1:0] pend, exp_done;
    logic       g, reuse, timed_out, seen, m;
    logic [4:0] ix;
    logic [6:0] exp_res;
    logic [9:0] exp_q[$];
    int         cnt, max_sa, d, sl, pl;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) str_mem[r][i] = 8'($urandom);
      for (int i = 0; i < 8; i++)  pat_mem[r][i] = 8'($urandom);
    end
    pend     = rq;
    req      = rq;
    keep_str = ks;
    while (pend != 2'b00) begin
      g        = (pend == 2'b11) ? ~lg_m : pend[1];
      reuse    = ks[g] & loaded_m & (owner_m == g);
      sl       = g ? int'(str_len_1) : int'(str_len_0);
      pl       = g ? int'(pat_len_1) : int'(pat_len_0);
      exp_done = 2'b01 << g;
      exp_q.delete();
      if (!reuse) for (int i = 0; i <= sl; i++) exp_q.push_back({2'b10, str_mem[g][i]});
      for (int i = 0; i <= pl; i++) exp_q.push_back({2'b01, pat_mem[g][i]});

      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!busy && cnt < 4);
      chk_eq("grant_latency", 32'(cnt), 32'd1);
      chk_eq("grant_sel", 32'(rd_sel), 32'(g));
      if (mode == 1) req[g] = 1'b0;

      max_sa = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        if (!rd_is_pat && int'(rd_addr) > max_sa) max_sa = int'(rd_addr);
        chk_eq("strobe", 32'({sme_isstring, sme_ispattern, sme_chardata}), 32'(exp_q[i]));
        if (mode == 2 && sme_ispattern) begin
          abort_job();
          return;
        end
        sme_valid       = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom);
        sme_match       = 1'($urandom);
        sme_match_index = 5'($urandom);
      end
      @(negedge clk);
      chk_eq("strobe_end", 32'({sme_isstring, sme_ispattern}), 32'd0);
      if (!reuse) chk_eq("str_addr_max", 32'(max_sa), 32'(sl));

      timed_out = 1'b0;
      if (mode == 3) begin
`ifdef SME_ARB_TIMEOUT_EN
        cnt = 0;
        while (done == 2'b00 && cnt < int'(TO_CYC) + 16) begin @(negedge clk); cnt++; end
        chk_eq("timeout_cycles", 32'(cnt), 32'(TO_CYC));
        timed_out = 1'b1;
`else
        seen = 1'b0;
        repeat (80) begin @(negedge clk); seen |= |done; end
        chk_eq("wait_no_exit", 32'(seen), 32'd0);
`endif
      end

      if (timed_out) begin
        exp_res = {1'b1, 1'b0, 5'd0};
      end else begin
        m  = fix_res ? fx_match : 1'($urandom);
        ix = fix_res ? fx_index : 5'($urandom);
        d  = $urandom_range(0, 4);
        repeat (d) @(negedge clk);
        chk_eq("done_early", 32'(done), 32'd0);
        sme_valid       = 1'b1;
        sme_match       = m;
        sme_match_index = ix;
        @(negedge clk);
        exp_res = {1'b0, m, ix};
      end
      chk_eq("done", 32'(done), 32'(exp_done));
      chk_eq("result", 32'({res_err, res_match, res_index}), 32'(exp_res));
      chk_eq("busy_resp", 32'(busy), 32'd1);

      // A valid seen during RESP must be ignored
      sme_valid       = 1'b1;
      sme_match       = 1'($urandom);
      sme_match_index = 5'($urandom);
      pend[g] = 1'b0;
      req     = pend;
      @(negedge clk);
      chk_eq("done_pulse_busy", 32'({done, busy}), 32'd0);
      chk_eq("result_hold", 32'({res_err, res_match, res_index}), 32'(exp_res));
      sme_valid = 1'b0;

      lg_m = g;
      if (!reuse) begin
        loaded_m = 1'b1;
        owner_m  = g;
      end
      if (timed_out) loaded_m = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] rq;
    int         mode;
    n_chk = 0; n_fail = 0;
    reset = 1'b0; req = '0; keep_str = '0;
    str_len_0 = '0; str_len_1 = '0; pat_len_0 = '0; pat_len_1 = '0;
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
    fix_res = 1'b0; fx_match = 1'b0; fx_index = '0;
    lg_m = 1'b1; loaded_m = 1'b0; owner_m = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) str_mem[r][i] = '0;
      for (int i = 0; i < 8; i++)  pat_mem[r][i] = '0;
    end

    repeat (3) @(negedge clk);
    chk_eq("reset_outputs", outs(), 32'd0);
    reset = 1'b1;

    // Basic job: 5 string bytes, 2 pattern bytes, match at index 3
    str_len_0 = 5'd4; pat_len_0 = 3'd1;
    fix_res = 1'b1; fx_match = 1'b1; fx_index = 5'd3;
    serve(2'b01, 2'b00, 0);
    fix_res = 1'b0;

    // Tie right after reset: requester 0 first, then 1
    pulse_reset();
    rand_lens();
    serve(2'b11, 2'b00, 0);

    // String reuse only for the current owner
    rand_lens(); serve(2'b01, 2'b00, 0);
    rand_lens(); serve(2'b01, 2'b01, 0);
    rand_lens(); serve(2'b10, 2'b10, 0);
    rand_lens(); serve(2'b10, 2'b10, 0);

    // Reset while streaming the pattern, then a keep_str job must resend the string
    rand_lens(); serve(2'b01, 2'b00, 0);
    rand_lens(); serve(2'b01, 2'b01, 2);
    rand_lens(); serve(2'b01, 2'b01, 0);

    // Longest string and pattern
    str_len_0 = 5'd31; pat_len_0 = 3'd7;
    serve(2'b01, 2'b00, 0);
    str_len_1 = 5'd31; pat_len_1 = 3'd7;
    serve(2'b10, 2'b00, 0);

    // Request withdrawn mid-job still completes
    rand_lens(); serve(2'b10, 2'b00, 1);

    // Engine never answers
    rand_lens(); serve(2'b01, 2'b00, 3);
    rand_lens(); serve(2'b01, 2'b01, 0);

    // Random mix
    for (int k = 0; k < 24; k++) begin
      rand_lens();
      case ($urandom_range(0, 2))
        0:       rq = 2'b01;
        1:       rq = 2'b10;
        default: rq = 2'b11;
      endcase
      mode = (rq != 2'b11 && $urandom_range(0, 3) == 0) ? 1 : 0;
      serve(rq, 2'($urandom), mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1);
  end

endmodule
